tag_lookup_ctrl: RTL and testbench

- Initiator/client side of the banked write-first tag memory.
- Accepts lookup requests (set, tag), reads all 8 ways of the set, and compares the tags against the valid bits.
- Reports hit/way. On an allocating miss, selects a victim way and issues the single-tag write back into the tag memory.
- Sits between the cache request front-end and one tag memory bank.

---
 rtl/tag_lookup_pkg.sv | 26 ++
 rtl/tag_victim_sel.sv | 23 ++
 rtl/tag_lookup_ctrl.sv | 124 ++++++++++++
 tb/tb_tag_lookup_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_lookup_pkg.sv
// Shared widths, types and helpers for the tag lookup controller and its victim selector.
package tag_lookup_pkg;

  localparam int TAG_W  = 16;
  localparam int SET_W  = 5;
  localparam int WAY_LG = 3;
  localparam int N_WAY  = 1 << WAY_LG;
  localparam int N_SET  = 1 << SET_W;

  typedef logic [WAY_LG-1:0] way_idx_t;

  typedef struct packed {
    logic             hit;
    way_idx_t         way;
    logic             evict;
    logic [TAG_W-1:0] evict_tag;
    logic [SET_W-1:0] set;
    logic [TAG_W-1:0] tag;
  } resp_t;

  function automatic logic [TAG_W-1:0] way_tag(input logic [N_WAY*TAG_W-1:0] data,
                                               input way_idx_t               way);
    return data[int'(way)*TAG_W +: TAG_W];
  endfunction

endpackage

// File: rtl/tag_victim_sel.sv
// Victim choice for an allocating miss: lowest invalid way, else the set's round-robin way.
module tag_victim_sel
  import tag_lookup_pkg::*;
(
  input  logic [N_WAY-1:0] valid_bits_i,
  input  way_idx_t         rr_ptr_i,
  output way_idx_t         victim_o,
  output logic             evict_o
);

  // NOTE: both outputs get a default before the loop, so no path leaves them unassigned (no latch).
  always_comb begin
    victim_o = rr_ptr_i;
    evict_o  = 1'b1;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (!valid_bits_i[i]) begin
        victim_o = way_idx_t'(i);
        evict_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Lookup pipeline (issue, compare, response) in front of one write-first tag memory bank;
// reports hit/way and, on an allocating miss, writes the request tag into a victim way.
module tag_lookup_ctrl
  import tag_lookup_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [SET_W-1:0]        req_set,
  input  logic [TAG_W-1:0]        req_tag,
  input  logic                    req_alloc,
  output logic [SET_W-1:0]        tm_r_addr,
  input  logic [N_WAY*TAG_W-1:0]  tm_r_data,
  input  logic [N_WAY-1:0]        tm_valid_bits,
  output logic                    tm_w_en,
  output logic [SET_W+WAY_LG-1:0] tm_w_addr,
  output logic [TAG_W-1:0]        tm_w_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_hit,
  output way_idx_t                resp_way,
  output logic                    resp_evict,
  output logic [TAG_W-1:0]        resp_evict_tag,
  output logic [SET_W-1:0]        resp_set,
  output logic [TAG_W-1:0]        resp_tag
);

  logic             s1_valid_q;
  logic [SET_W-1:0] s1_set_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_alloc_q;
  logic             resp_valid_q;
  resp_t            resp_q;
  resp_t            resp_d;
  way_idx_t         rr_q [N_SET];

  logic             advance;
  logic [N_WAY-1:0] hit_vec;
  logic             s1_hit;
  way_idx_t         hit_way;
  way_idx_t         victim;
  logic             victim_evict;

  assign advance   = !resp_valid_q || resp_ready;
  assign req_ready = reset && (advance || !s1_valid_q);
  // A stalled S1 keeps re-reading its own set so its tag data tracks any bypassed write.
  assign tm_r_addr = req_ready ? req_set : s1_set_q;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int i = 0; i < N_WAY; i++) begin
      hit_vec[i] = tm_valid_bits[i] && (way_tag(tm_r_data, way_idx_t'(i)) == s1_tag_q);
    end
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = way_idx_t'(i);
    end
  end

  assign s1_hit = |hit_vec;

  tag_victim_sel u_victim_sel (
    .valid_bits_i (tm_valid_bits),
    .rr_ptr_i     (rr_q[s1_set_q]),
    .victim_o     (victim),
    .evict_o      (victim_evict)
  );

  always_comb begin
    resp_d     = '0;
    resp_d.hit = s1_hit;
    resp_d.set = s1_set_q;
    resp_d.tag = s1_tag_q;
    if (s1_hit) begin
      resp_d.way = hit_way;
    end else if (s1_alloc_q) begin
      resp_d.way   = victim;
      resp_d.evict = victim_evict;
      if (victim_evict) resp_d.evict_tag = way_tag(tm_r_data, victim);
    end
  end

  // Issued only on the cycle S1 hands off, so a stalled miss writes exactly once.
  assign tm_w_en   = reset && s1_valid_q && !s1_hit && s1_alloc_q && advance;
  assign tm_w_addr = {s1_set_q, victim};
  assign tm_w_data = s1_tag_q;

  // NOTE: S1 payload registers are qualified by s1_valid_q, so they carry no reset.
  always_ff @(posedge clk) begin
    if (req_ready) begin
      s1_set_q   <= req_set;
      s1_tag_q   <= req_tag;
      s1_alloc_q <= req_alloc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      // NOTE: rr_q is a small flop array, not a RAM, so it clears in the same reset cycle.
      for (int s = 0; s < N_SET; s++) rr_q[s] <= '0;
    end else begin
      if (req_ready) s1_valid_q <= req_valid;
      if (advance) begin
        resp_valid_q <= s1_valid_q;
        if (s1_valid_q) resp_q <= resp_d;
      end
      if (tm_w_en && victim_evict) rr_q[s1_set_q] <= rr_q[s1_set_q] + way_idx_t'(1);
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_hit       = resp_q.hit;
  assign resp_way       = resp_q.way;
  assign resp_evict     = resp_q.evict;
  assign resp_evict_tag = resp_q.evict_tag;
  assign resp_set       = resp_q.set;
  assign resp_tag       = resp_q.tag;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Scoreboard bench for tag_lookup_ctrl with a write-first tag memory model and a set/way reference model.
module tb_tag_lookup_ctrl;
  import tag_lookup_pkg::*;

  typedef struct {
    logic [SET_W-1:0] set;
    way_idx_t         way;
    logic [TAG_W-1:0] data;
  } wr_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    req_valid = 1'b0;
  logic                    req_ready;
  logic [SET_W-1:0]        req_set = '0;
  logic [TAG_W-1:0]        req_tag = '0;
  logic                    req_alloc = 1'b0;
  logic [SET_W-1:0]        tm_r_addr;
  logic [N_WAY*TAG_W-1:0]  tm_r_data = '0;
  logic [N_WAY-1:0]        tm_valid_bits = '0;
  logic                    tm_w_en;
  logic [SET_W+WAY_LG-1:0] tm_w_addr;
  logic [TAG_W-1:0]        tm_w_data;
  logic                    resp_valid;
  logic                    resp_ready = 1'b1;
  logic                    resp_hit;
  way_idx_t                resp_way;
  logic                    resp_evict;
  logic [TAG_W-1:0]        resp_evict_tag;
  logic [SET_W-1:0]        resp_set;
  logic [TAG_W-1:0]        resp_tag;

  tag_lookup_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_set        (req_set),
    .req_tag        (req_tag),
    .req_alloc      (req_alloc),
    .tm_r_addr      (tm_r_addr),
    .tm_r_data      (tm_r_data),
    .tm_valid_bits  (tm_valid_bits),
    .tm_w_en        (tm_w_en),
    .tm_w_addr      (tm_w_addr),
    .tm_w_data      (tm_w_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_hit       (resp_hit),
    .resp_way       (resp_way),
    .resp_evict     (resp_evict),
    .resp_evict_tag (resp_evict_tag),
    .resp_set       (resp_set),
    .resp_tag       (resp_tag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Write-first tag memory bank: a write at an edge is visible to a read issued at the same edge.
  logic [TAG_W-1:0] mem_tag [N_SET][N_WAY] = '{default: '0};
  logic             mem_vld [N_SET][N_WAY] = '{default: 1'b0};
  logic             poke_en  = 1'b0;
  logic [SET_W-1:0] poke_set = '0;
  way_idx_t         poke_way = '0;
  logic [TAG_W-1:0] poke_tag = '0;

  always @(posedge clk) begin : tag_mem
    logic [N_WAY*TAG_W-1:0] rd;
    logic [N_WAY-1:0]       rv;
    if (tm_w_en) begin
      mem_tag[tm_w_addr[SET_W+WAY_LG-1:WAY_LG]][tm_w_addr[WAY_LG-1:0]] = tm_w_data;
      mem_vld[tm_w_addr[SET_W+WAY_LG-1:WAY_LG]][tm_w_addr[WAY_LG-1:0]] = 1'b1;
    end
    if (poke_en) begin
      mem_tag[poke_set][poke_way] = poke_tag;
      mem_vld[poke_set][poke_way] = 1'b1;
    end
    for (int i = 0; i < N_WAY; i++) begin
      rd[i*TAG_W +: TAG_W] = mem_tag[tm_r_addr][i];
      rv[i]                = mem_vld[tm_r_addr][i];
    end
    tm_r_data     <= rd;
    tm_valid_bits <= rv;
  end

  logic rand_mode   = 1'b0;
  logic ready_force = 1'b1;

  always @(posedge clk) begin
    #2;
    resp_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Reference model: the cache contents as the sequence of accepted requests leaves them.
  logic [TAG_W-1:0] ref_tag [N_SET][N_WAY];
  logic             ref_vld [N_SET][N_WAY];
  int               ref_rr  [N_SET];
  resp_t            exp_q [$];
  wr_t              wr_q  [$];

  task automatic model_accept(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t, input logic a);
    resp_t e;
    int    way;
    e     = '0;
    e.set = s;
    e.tag = t;
    way   = -1;
    for (int i = 0; i < N_WAY; i++)
      if (way < 0 && ref_vld[s][i] && ref_tag[s][i] == t) way = i;
    if (way >= 0) begin
      e.hit = 1'b1;
      e.way = way_idx_t'(way);
    end else if (a) begin
      for (int i = 0; i < N_WAY; i++)
        if (way < 0 && !ref_vld[s][i]) way = i;
      if (way < 0) begin
        way         = ref_rr[s];
        e.evict     = 1'b1;
        e.evict_tag = ref_tag[s][way];
        ref_rr[s]   = (ref_rr[s] + 1) % N_WAY;
      end
      e.way          = way_idx_t'(way);
      ref_tag[s][way] = t;
      ref_vld[s][way] = 1'b1;
      wr_q.push_back('{set: s, way: way_idx_t'(way), data: t});
    end
    exp_q.push_back(e);
  endtask

  int    outstanding = 0;
  logic  prev_stall  = 1'b0;
  resp_t prev_r      = '0;

  always @(negedge clk) begin : monitor
    resp_t got;
    resp_t e;
    wr_t   w;
    logic  exp_ready;
    got = '{hit: resp_hit, way: resp_way, evict: resp_evict, evict_tag: resp_evict_tag,
            set: resp_set, tag: resp_tag};
    if (!reset) begin
      check("reset_req_ready", 64'(req_ready), 64'(0));
      check("reset_w_en", 64'(tm_w_en), 64'(0));
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      exp_ready = !resp_valid || resp_ready || (outstanding - int'(resp_valid)) == 0;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      if (prev_stall) begin
        check("hold_valid", 64'(resp_valid), 64'(1));
        check("hold_fields", 64'(got), 64'(prev_r));
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'(resp_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("resp_hit", 64'(resp_hit), 64'(e.hit));
          check("resp_way", 64'(resp_way), 64'(e.way));
          check("resp_evict", 64'(resp_evict), 64'(e.evict));
          if (e.evict) check("resp_evict_tag", 64'(resp_evict_tag), 64'(e.evict_tag));
          check("resp_set", 64'(resp_set), 64'(e.set));
          check("resp_tag", 64'(resp_tag), 64'(e.tag));
        end
      end
      if (tm_w_en) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 64'(tm_w_en), 64'(0));
        end else begin
          w = wr_q.pop_front();
          check("w_addr", 64'(tm_w_addr), 64'({w.set, w.way}));
          check("w_data", 64'(tm_w_data), 64'(w.data));
        end
      end
      prev_stall  = resp_valid && !resp_ready;
      prev_r      = got;
      outstanding = outstanding + int'(req_valid && req_ready) - int'(resp_valid && resp_ready);
    end
  end

  task automatic send(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t, input logic a);
    int n   = 0;
    bit acc = 1'b0;
    req_valid = 1'b1;
    req_set   = s;
    req_tag   = t;
    req_alloc = a;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      else n++;
    end
    if (acc) model_accept(s, t, a);
    else check("req_accept_timeout", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [SET_W-1:0] s, input way_idx_t w, input logic [TAG_W-1:0] t);
    poke_en  = 1'b1;
    poke_set = s;
    poke_way = w;
    poke_tag = t;
    @(posedge clk);
    #1;
    poke_en    = 1'b0;
    ref_tag[s][w] = t;
    ref_vld[s][w] = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : driver
    for (int s = 0; s < N_SET; s++) begin
      ref_rr[s] = 0;
      for (int w = 0; w < N_WAY; w++) begin
        ref_tag[s][w] = '0;
        ref_vld[s][w] = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_fields", 64'({resp_hit, resp_way, resp_evict, resp_evict_tag, resp_set, resp_tag}), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;

    // Latency: accepted at edge N, response visible after edge N+1; also a no-alloc miss.
    send(SET_W'(7), TAG_W'(16'h0777), 1'b0);
    @(negedge clk);
    check("lat_after_n", 64'(resp_valid), 64'(0));
    @(negedge clk);
    check("lat_after_n1", 64'(resp_valid), 64'(1));
    @(posedge clk);
    #1;

    // Empty-set fill followed immediately by the same lookup through the write-first bypass.
    send(SET_W'(3), TAG_W'(16'h1234), 1'b1);
    send(SET_W'(3), TAG_W'(16'h1234), 1'b1);
    drain();

    // Fill set 5, then ten evictions (pointer wraps); a no-alloc miss mid-way leaves rr alone.
    for (int i = 0; i < N_WAY; i++) send(SET_W'(5), TAG_W'(16'h5000 + i), 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) send(SET_W'(5), TAG_W'(16'hBEEF), 1'b0);
      send(SET_W'(5), TAG_W'(16'h5100 + k), 1'b1);
    end
    drain();

    // Duplicate tag in two ways: the lower way must win.
    poke(SET_W'(20), way_idx_t'(5), TAG_W'(16'hD00D));
    poke(SET_W'(20), way_idx_t'(2), TAG_W'(16'hD00D));
    send(SET_W'(20), TAG_W'(16'hD00D), 1'b1);
    drain();

    // Miss stalled in S1 behind a held response: one write, issued on release.
    ready_force = 1'b0;
    send(SET_W'(10), TAG_W'(16'hAAAA), 1'b1);
    send(SET_W'(11), TAG_W'(16'hBBBB), 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("stall_req_ready", 64'(req_ready), 64'(0));
      check("stall_w_en", 64'(tm_w_en), 64'(0));
    end
    @(posedge clk);
    #1 ready_force = 1'b1;
    drain();

    // Random traffic over a few sets with a small tag pool and random back-pressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      send(SET_W'(16 + $urandom_range(0, 3)), TAG_W'(32'hA000 + $urandom_range(0, 11)),
           1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_mode = 1'b0;
    drain();

    // Reset with two evicting requests in flight.
    ready_force = 1'b0;
    send(SET_W'(5), TAG_W'(16'h5200), 1'b1);
    send(SET_W'(5), TAG_W'(16'h5201), 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    wr_q.delete();
    for (int s = 0; s < N_SET; s++) begin
      ref_rr[s] = 0;
      for (int w = 0; w < N_WAY; w++) begin
        ref_tag[s][w] = mem_tag[s][w];
        ref_vld[s][w] = mem_vld[s][w];
      end
    end
    @(negedge clk);
    check("post_rst_resp_valid", 64'(resp_valid), 64'(0));
    check("post_rst_w_en", 64'(tm_w_en), 64'(0));
    check("post_rst_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1 ready_force = 1'b1;
    send(SET_W'(5), TAG_W'(16'h5300), 1'b1);
    send(SET_W'(5), TAG_W'(16'h5301), 1'b1);
    drain();

    check("final_resp_queue", 64'(exp_q.size()), 64'(0));
    check("final_write_queue", 64'(wr_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
